mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM pipeline stage of the five-stage core, sitting between the EX/MEM register and the WB stage. It consumes `MemWrDataSrc` from the load-store forwarding unit to choose store data: either the EX/MEM `rt` value or the value currently being written back. It runs a request/acknowledge handshake with data memory and generates byte lanes and load extension. It also stalls upstream while an access is outstanding and drives the MEM/WB pipeline register.

## Interface
- `ADDR_W`, default 32: data-memory address width. Data path is fixed at 32 bits.

Ports:
- `clk` in 1: single core clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `MEM_valid` in 1: EX/MEM holds a real instruction.
- `MEM_MemRd` in 1: load.
- `MEM_MemWr` in 1: store.
- `MEM_size` in 2: 00 byte, 01 half, 10 word (11 treated as word).
- `MEM_unsigned` in 1: zero-extend loads.
- `MEM_ALUResult` in 32: effective address, or result for non-memory ops.
- `MEM_rtData` in 32: store data from EX/MEM.
- `MEM_RegWr` in 1: destination write enable.
- `MEM_RegDstAddr` in 5: destination register.
- `MemWrDataSrc` in 1: 1 selects `WB_RegWrData` as store data, 0 selects `MEM_rtData`.
- `dm_req` out 1: memory request, held until acknowledged.
- `dm_we` out 1: 1 store, 0 load.
- `dm_addr` out ADDR_W: word-aligned address (`[1:0]` = 00).
- `dm_be` out 4: byte enables.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_ack` in 1: request accepted/completed this cycle.
- `dm_rdata` in 32: load word, valid when `dm_ack`.
- `MEM_stall` out 1: hold IF..MEM this cycle.
- `WB_RegWr` out 1: registered write enable to the register file.
- `WB_RegDstAddr` out 5: registered destination.
- `WB_RegWrData` out 32: registered write-back data. Also the internal forwarding source.
- `WB_ale` out 1: registered address-misalignment flag.

## Operation
- Memory op: `op` = `MEM_valid & (MEM_MemRd | MEM_MemWr)`.
- Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- FSM has two states, IDLE and WAIT.
- IDLE, no `op`: WB register loads `MEM_RegWr & MEM_valid`, `MEM_RegDstAddr` and `MEM_ALUResult`; `WB_ale`=0.
- IDLE, `op` misaligned: no request; WB loads `RegWr`=0 and `WB_ale`=1; stay in IDLE.
- IDLE, `op` aligned: latch `dm_we`, `dm_addr`, `dm_be`, `dm_wdata`, size, unsigned and destination; go to WAIT.
  - Store data is selected by `MemWrDataSrc` in this cycle only. The latched copy is used for the rest of the access, because the WB value is gone once WB bubbles.
- WAIT: `dm_req`=1 and outputs are stable. On `dm_ack`, WB loads the result (load: extended data; store: `RegWr`=0) and the FSM returns to IDLE. Without `dm_ack`, WB loads a bubble (`RegWr`=0).
- Store lanes:
  - byte: `wdata`={4{b}}, `be`=0001<<`addr[1:0]`.
  - half: `wdata`={2{h}}, `be`=0011 (`addr[1]`=0) or 1100.
  - word: `be`=1111.
- Load extraction: select the byte/half by the latched `addr[1:0]`, then sign-extend (`MEM_unsigned`=0) or zero-extend.
- `MEM_stall` = (IDLE & aligned `op`) | (WAIT & ~`dm_ack`). It is combinational, so upstream advances in the ack cycle.
- `dm_ack` while in IDLE is ignored.

## Timing
- Reset values: state=IDLE, `dm_req`=0, `dm_we`=0, `dm_addr`=0, `dm_be`=0, `dm_wdata`=0, `WB_RegWr`=0, `WB_RegDstAddr`=0, `WB_RegWrData`=0, `WB_ale`=0. `MEM_stall` is 0 while `rst`=1.
- Non-memory op and misaligned op: 1 cycle, WB valid the cycle after.
- Aligned access: issue at cycle T, `dm_req` high from T+1. Ack at cycle T+k (k≥1) puts WB valid at T+k+1. Minimum 2 cycles, stall held T..T+k-1.
- Back-to-back accesses: a second `op` presented in the ack cycle is evaluated in IDLE the next cycle. No request overlap; `dm_req` drops for at least one cycle.
- `rst` in WAIT: IDLE next cycle, `dm_req`=0, no WB write. A late `dm_ack` is ignored.

## Test plan
- ALU op, `MEM_ALUResult`=0x1234, `RegDst`=5 -> next cycle `WB_RegWr`=1, `WB_RegWrData`=0x1234, no `dm_req`, no stall.
- Load byte at 0x103, `dm_rdata`=0x80FF_FF00, `MEM_unsigned`=0, ack after 3 cycles -> `dm_addr`=0x100, `be`=1000; stall for 3 cycles; `WB_RegWrData`=0xFFFF_FF80.
- Store half at 0x202, `MemWrDataSrc`=1, `WB_RegWrData`=0xAAAA_BEEF, `MEM_rtData`=0x1111_1111 -> `dm_wdata`=0xBEEF_BEEF, `be`=1100. Data unchanged across a 4-cycle ack delay.
- Load word at 0x3 -> no `dm_req`; next cycle `WB_ale`=1, `WB_RegWr`=0; no stall.
- `rst` asserted in WAIT with `dm_ack` arriving the next cycle -> `dm_req`=0, `WB_RegWr`=0, state IDLE; the following ALU op completes normally.
- Two back-to-back word stores, ack 1 cycle after each `dm_req` -> each request is a distinct assertion with correct address and data, and `MEM_stall` is never deasserted mid-access.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory handshake, byte lanes, load extension, MEM/WB register
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_valid,
  input  logic              MEM_MemRd,
  input  logic              MEM_MemWr,
  input  logic [1:0]        MEM_size,
  input  logic              MEM_unsigned,
  input  logic [31:0]       MEM_ALUResult,
  input  logic [31:0]       MEM_rtData,
  input  logic              MEM_RegWr,
  input  logic [4:0]        MEM_RegDstAddr,
  input  logic              MemWrDataSrc,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              MEM_stall,
  output logic              WB_RegWr,
  output logic [4:0]        WB_RegDstAddr,
  output logic [31:0]       WB_RegWrData,
  output logic              WB_ale
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;

  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic        regwr_q;
  logic [4:0]  dst_q;

  logic        op;
  logic        misaligned;
  logic [31:0] st_data;
  logic [31:0] lane_data;
  logic [3:0]  lane_be;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;

  assign op = MEM_valid & (MEM_MemRd | MEM_MemWr);

  always_comb begin
    misaligned = 1'b0;
    case (MEM_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = MEM_ALUResult[0];
      default: misaligned = |MEM_ALUResult[1:0];
    endcase
  end

  // Forwarded value is only trustworthy in the issue cycle; it is latched into dm_wdata.
  assign st_data = MemWrDataSrc ? WB_RegWrData : MEM_rtData;

  always_comb begin
    lane_data = st_data;
    lane_be   = 4'b1111;
    case (MEM_size)
      2'b00: begin
        lane_data = {4{st_data[7:0]}};
        lane_be   = 4'b0001 << MEM_ALUResult[1:0];
      end
      2'b01: begin
        lane_data = {2{st_data[15:0]}};
        lane_be   = MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_data = st_data;
        lane_be   = 4'b1111;
      end
    endcase
  end

  assign byte_sel = dm_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = dm_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = dm_rdata;
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   ld_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: ld_ext = dm_rdata;
    endcase
  end

  assign MEM_stall = ~rst & (((state == S_IDLE) & op & ~misaligned) |
                             ((state == S_WAIT) & ~dm_ack));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_be         <= 4'b0000;
      dm_wdata      <= 32'h0;
      size_q        <= 2'b00;
      off_q         <= 2'b00;
      uns_q         <= 1'b0;
      regwr_q       <= 1'b0;
      dst_q         <= 5'd0;
      WB_RegWr      <= 1'b0;
      WB_RegDstAddr <= 5'd0;
      WB_RegWrData  <= 32'h0;
      WB_ale        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          WB_ale <= 1'b0;
          if (!op) begin
            WB_RegWr      <= MEM_RegWr & MEM_valid;
            WB_RegDstAddr <= MEM_RegDstAddr;
            WB_RegWrData  <= MEM_ALUResult;
          end else if (misaligned) begin
            WB_RegWr      <= 1'b0;
            WB_ale        <= 1'b1;
            WB_RegDstAddr <= MEM_RegDstAddr;
            WB_RegWrData  <= MEM_ALUResult;
          end else begin
            WB_RegWr <= 1'b0;
            dm_req   <= 1'b1;
            dm_we    <= MEM_MemWr;
            dm_addr  <= {MEM_ALUResult[ADDR_W-1:2], 2'b00};
            dm_be    <= lane_be;
            dm_wdata <= lane_data;
            size_q   <= MEM_size;
            off_q    <= MEM_ALUResult[1:0];
            uns_q    <= MEM_unsigned;
            regwr_q  <= MEM_RegWr;
            dst_q    <= MEM_RegDstAddr;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          WB_ale <= 1'b0;
          if (dm_ack) begin
            dm_req        <= 1'b0;
            state         <= S_IDLE;
            WB_RegWr      <= regwr_q & ~dm_we;
            WB_RegDstAddr <= dst_q;
            if (!dm_we) WB_RegWrData <= ld_ext;
          end else begin
            WB_RegWr <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed and random checks of mem_access_stage against a behavioural model
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_valid, MEM_MemRd, MEM_MemWr, MEM_unsigned, MEM_RegWr, MemWrDataSrc;
  logic [1:0]  MEM_size;
  logic [31:0] MEM_ALUResult, MEM_rtData;
  logic [4:0]  MEM_RegDstAddr;
  logic        dm_req, dm_we, dm_ack, MEM_stall, WB_RegWr, WB_ale;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, WB_RegWrData;
  logic [3:0]  dm_be;
  logic [4:0]  WB_RegDstAddr;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .MEM_valid(MEM_valid), .MEM_MemRd(MEM_MemRd), .MEM_MemWr(MEM_MemWr),
    .MEM_size(MEM_size), .MEM_unsigned(MEM_unsigned), .MEM_ALUResult(MEM_ALUResult),
    .MEM_rtData(MEM_rtData), .MEM_RegWr(MEM_RegWr), .MEM_RegDstAddr(MEM_RegDstAddr),
    .MemWrDataSrc(MemWrDataSrc), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .MEM_stall(MEM_stall), .WB_RegWr(WB_RegWr), .WB_RegDstAddr(WB_RegDstAddr),
    .WB_RegWrData(WB_RegWrData), .WB_ale(WB_ale)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_wb = 32'h0;
  logic        fwd_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * off[1])) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Presents one instruction at a falling edge and follows it to its WB result.
  task automatic run_op(input logic valid, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] rt,
                        input logic regwr, input logic [4:0] dst, input logic src,
                        input int lat, input logic [31:0] rdata);
    logic        op, mis;
    logic [31:0] sd, exp_wdata, exp_data;
    logic [3:0]  exp_be;
    MEM_valid = valid; MEM_MemRd = rd; MEM_MemWr = wr; MEM_size = sz; MEM_unsigned = uns;
    MEM_ALUResult = addr; MEM_rtData = rt; MEM_RegWr = regwr; MEM_RegDstAddr = dst;
    MemWrDataSrc = src; dm_ack = 1'b0; dm_rdata = $urandom;
    op  = valid & (rd | wr);
    mis = (sz == 2'd1 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
    sd  = src ? exp_wb : rt;
    if (sz == 2'd0) begin
      exp_wdata = (sd & 32'hFF) * 32'h0101_0101;
      exp_be    = 4'(1 << addr[1:0]);
    end else if (sz == 2'd1) begin
      exp_wdata = (sd & 32'hFFFF) * 32'h0001_0001;
      exp_be    = 4'(3 << (2 * addr[1]));
    end else begin
      exp_wdata = sd;
      exp_be    = 4'hF;
    end
    #1;
    chk("idle_no_req", {31'b0, dm_req}, 32'd0);
    chk("issue_stall", {31'b0, MEM_stall}, {31'b0, op & ~mis});
    @(negedge clk);
    if (!op || mis) begin
      chk("wb_regwr", {31'b0, WB_RegWr}, {31'b0, ~op & regwr & valid});
      chk("wb_ale", {31'b0, WB_ale}, {31'b0, op & mis});
      chk("no_req", {31'b0, dm_req}, 32'd0);
      if (!op) begin
        chk("wb_data", WB_RegWrData, addr);
        chk("wb_dst", {27'b0, WB_RegDstAddr}, {27'b0, dst});
        exp_wb = addr; fwd_known = 1'b1;
      end else begin
        fwd_known = 1'b0;
      end
    end else begin
      for (int i = 1; i <= lat; i++) begin
        chk("req", {31'b0, dm_req}, 32'd1);
        chk("we", {31'b0, dm_we}, {31'b0, wr});
        chk("addr", dm_addr, addr & 32'hFFFF_FFFC);
        chk("be", {28'b0, dm_be}, {28'b0, exp_be});
        if (wr) chk("wdata", dm_wdata, exp_wdata);
        if (i > 1) chk("bubble", {31'b0, WB_RegWr}, 32'd0);
        MEM_rtData = $urandom; MemWrDataSrc = 1'($urandom);
        if (i == lat) begin dm_ack = 1'b1; dm_rdata = rdata; end
        else dm_rdata = $urandom;
        #1 chk("wait_stall", {31'b0, MEM_stall}, {31'b0, i != lat});
        @(negedge clk);
      end
      dm_ack = 1'b0;
      chk("ale_clear", {31'b0, WB_ale}, 32'd0);
      if (wr) begin
        chk("store_no_wb", {31'b0, WB_RegWr}, 32'd0);
        fwd_known = 1'b0;
      end else begin
        exp_data = load_ext(rdata, addr[1:0], sz, uns);
        chk("load_regwr", {31'b0, WB_RegWr}, {31'b0, regwr});
        chk("load_dst", {27'b0, WB_RegDstAddr}, {27'b0, dst});
        chk("load_data", WB_RegWrData, exp_data);
        exp_wb = exp_data; fwd_known = 1'b1;
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  kind;
    logic [1:0]  sz;
    rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
    MEM_valid = 1'b1; MEM_MemRd = 1'b1; MEM_MemWr = 1'b0; MEM_size = 2'd2; MEM_unsigned = 1'b0;
    MEM_ALUResult = 32'h10; MEM_rtData = 32'h0; MEM_RegWr = 1'b1; MEM_RegDstAddr = 5'd1;
    MemWrDataSrc = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", {31'b0, MEM_stall}, 32'd0);
    chk("rst_req", {31'b0, dm_req}, 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_be", {28'b0, dm_be}, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_wb", {WB_RegWrData[29:0], WB_RegWr, WB_ale}, 32'd0);
    chk("rst_wbhi", {25'b0, WB_RegWrData[31:30], WB_RegDstAddr}, 32'd0);
    rst = 1'b0;

    run_op(1, 0, 0, 2'd2, 0, 32'h1234, 32'h0, 1, 5'd5, 0, 1, 32'h0);
    run_op(1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 1, 5'd7, 0, 3, 32'h80FF_FF00);
    run_op(1, 0, 0, 2'd2, 0, 32'hAAAA_BEEF, 32'h0, 1, 5'd9, 0, 1, 32'h0);
    run_op(1, 0, 1, 2'd1, 0, 32'h202, 32'h1111_1111, 0, 5'd0, 1, 4, 32'h0);
    run_op(1, 1, 0, 2'd2, 0, 32'h3, 32'h0, 1, 5'd3, 0, 1, 32'h0);

    // Reset while waiting, then a late acknowledge that must be ignored.
    MEM_valid = 1'b1; MEM_MemRd = 1'b1; MEM_MemWr = 1'b0; MEM_size = 2'd2;
    MEM_ALUResult = 32'h40; MEM_RegWr = 1'b1; MEM_RegDstAddr = 5'd4;
    @(negedge clk);
    chk("pre_rst_req", {31'b0, dm_req}, 32'd1);
    rst = 1'b1; MEM_valid = 1'b0;
    #1 chk("rst_wait_stall", {31'b0, MEM_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    chk("rst_wait_req", {31'b0, dm_req}, 32'd0);
    chk("rst_wait_wb", {31'b0, WB_RegWr}, 32'd0);
    @(negedge clk);
    dm_ack = 1'b0;
    chk("late_ack_req", {31'b0, dm_req}, 32'd0);
    chk("late_ack_wb", {31'b0, WB_RegWr}, 32'd0);
    fwd_known = 1'b0;
    run_op(1, 0, 0, 2'd2, 0, 32'h5555, 32'h0, 1, 5'd6, 0, 1, 32'h0);

    run_op(1, 0, 1, 2'd2, 0, 32'h400, 32'hCAFE_0001, 0, 5'd0, 0, 1, 32'h0);
    run_op(1, 0, 1, 2'd2, 0, 32'h404, 32'hCAFE_0002, 0, 5'd0, 0, 1, 32'h0);

    for (int n = 0; n < 60; n++) begin
      kind = 2'($urandom_range(0, 2));
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'd0) ? 32'hFFFF_FFFF :
                                               (sz == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
      run_op(1'($urandom_range(0, 4) != 0), kind == 2'd1, kind == 2'd2, sz, 1'($urandom),
             a, $urandom, 1'($urandom), 5'($urandom), fwd_known & 1'($urandom),
             $urandom_range(1, 4), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
